// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the signed calculator with 7-segment output.
// Holds operation codes, the BCD converter state encoding and the segment
// patterns (gfedcba, active-low).
package calc_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } calc_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Decimal digit to segment pattern; anything above 9 is shown blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: seg_digit = SEG_0;
      4'd1: seg_digit = SEG_1;
      4'd2: seg_digit = SEG_2;
      4'd3: seg_digit = SEG_3;
      4'd4: seg_digit = SEG_4;
      4'd5: seg_digit = SEG_5;
      4'd6: seg_digit = SEG_6;
      4'd7: seg_digit = SEG_7;
      4'd8: seg_digit = SEG_8;
      4'd9: seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, one shift per clock.
// The operand is captured on the start edge (IDLE -> LOAD). LOAD performs the
// first shift, SHIFT performs the remaining WIDTH-1, so busy is high for
// exactly WIDTH cycles. The final shift writes the bcd output register
// directly; done is high during that final cycle, so anything latched on
// done changes on the same edge as bcd. DONE is a one-cycle settle state
// with busy low, and a new start is accepted there as in IDLE.
// Handshake: start is a single-cycle request honoured only while busy is low;
// requests while busy is high are dropped, not queued.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd
);

  calc_state_e      state;
  logic [3:0]       shift_cnt;
  logic [11:0]      work_bcd;
  logic [WIDTH-1:0] work_bin;
  logic [11:0]      adj_bcd;
  logic [11:0]      sh_bcd;
  logic [WIDTH-1:0] sh_bin;

  localparam logic [3:0] LAST_SHIFT = 4'(WIDTH - 1);

  // One double-dabble step: add 3 to nibbles >= 5, then shift left one bit.
  always_comb begin
    adj_bcd = work_bcd;
    for (int i = 0; i < 3; i++) begin
      if (work_bcd[4*i +: 4] >= 4'd5)
        adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
    end
    sh_bcd = {adj_bcd[10:0], work_bin[WIDTH-1]};
    sh_bin = {work_bin[WIDTH-2:0], 1'b0};
  end

  // Status decoded from the state register.
  always_comb begin
    busy = (state == LOAD) || (state == SHIFT);
    done = (state == SHIFT) && (shift_cnt == LAST_SHIFT);
  end

  // Converter sequencer; reset aborts any conversion in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_cnt <= 4'd0;
      work_bcd  <= 12'd0;
      work_bin  <= '0;
      bcd       <= 12'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work_bin  <= bin;
            work_bcd  <= 12'd0;
            shift_cnt <= 4'd0;
            state     <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          work_bcd  <= sh_bcd;
          work_bin  <= sh_bin;
          shift_cnt <= 4'd1;
          state     <= SHIFT;
        end
        SHIFT: begin
          work_bcd  <= sh_bcd;
          work_bin  <= sh_bin;
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == LAST_SHIFT) begin
            bcd   <= sh_bcd;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/signed_calc_7seg.sv
// signed_calc_7seg: signed add/sub/negate/pass calculator triggered by a
// button rising edge, with sign + 3-digit decimal shown on an 8-digit
// multiplexed active-low 7-segment display.
// Optional build macro CALC_SATURATE_EN: clamp overflowing results to the
// representable extreme instead of wrapping.
// Handshake: a button rising edge is a request; it is accepted only while the
// converter is not busy, and edges seen while busy are dropped.
module signed_calc_7seg
  import calc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             calc_button,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [7:0]       an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0]    REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [WIDTH-1:0] VAL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] VAL_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             btn_q;
  logic             accept;
  logic [WIDTH-1:0] sum_v;
  logic [WIDTH-1:0] diff_v;
  logic [WIDTH-1:0] neg_v;
  logic [WIDTH-1:0] raw_v;
  logic [WIDTH-1:0] next_result;
  logic             next_ovf;
  logic             true_neg;
  logic             next_sign;
  logic [WIDTH-1:0] next_mag;
  logic             pending_sign;
  logic             disp_sign;
  logic             conv_done;
  logic [11:0]      disp_bcd;
  logic [RW-1:0]    refresh_cnt;
  logic [2:0]       sel;

  // Accept a rising button edge only when no conversion is running.
  always_comb accept = calc_button & ~btn_q & ~busy;

  // Wrap-around arithmetic, signed overflow and the optional clamp.
  always_comb begin
    sum_v    = a + b;
    diff_v   = a + ~b + WIDTH'(1);
    neg_v    = ~a + WIDTH'(1);
    raw_v    = a;
    next_ovf = 1'b0;
    true_neg = a[WIDTH-1];
    case (op)
      OP_ADD: begin
        raw_v    = sum_v;
        next_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_v[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        raw_v    = diff_v;
        next_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_v[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG: begin
        raw_v    = neg_v;
        next_ovf = (a == VAL_MIN);
        true_neg = 1'b0;  // only -MIN overflows, and its true value is positive
      end
      default: begin
        raw_v    = a;
        next_ovf = 1'b0;
      end
    endcase
`ifdef CALC_SATURATE_EN
    if (next_ovf)
      next_result = true_neg ? VAL_MIN : VAL_MAX;
    else
      next_result = raw_v;
`else
    next_result = raw_v;
`endif
    // Unsigned magnitude: -MIN negates to itself, which read unsigned is 2^(W-1).
    next_sign = next_result[WIDTH-1];
    next_mag  = next_sign ? (~next_result + WIDTH'(1)) : next_result;
  end

  // Button history, result/overflow registers and the sign awaiting display.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q        <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      pending_sign <= 1'b0;
      disp_sign    <= 1'b0;
    end else begin
      btn_q <= calc_button;
      if (accept) begin
        result       <= next_result;
        overflow     <= next_ovf;
        pending_sign <= next_sign;
      end
      if (conv_done)
        disp_sign <= pending_sign;
    end
  end

  bin_to_bcd_seq #(
    .WIDTH(WIDTH)
  ) u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(accept),
    .bin  (next_mag),
    .busy (busy),
    .done (conv_done),
    .bcd  (disp_bcd)
  );

  // Digit slot timer: advance the digit select once every REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      sel         <= 3'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      sel         <= sel + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Active-low digit enable for the selected slot.
  always_comb an = ~(8'b0000_0001 << sel);

  // Segment content for the selected slot, with leading-zero blanking.
  always_comb begin
    seg = SEG_BLANK;
    case (sel)
      3'd0: seg = seg_digit(disp_bcd[3:0]);
      3'd1: if ((disp_bcd[11:8] != 4'd0) || (disp_bcd[7:4] != 4'd0))
              seg = seg_digit(disp_bcd[7:4]);
      3'd2: if (disp_bcd[11:8] != 4'd0)
              seg = seg_digit(disp_bcd[11:8]);
      3'd3: if (disp_sign) seg = SEG_MINUS;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
